// File: rtl/arithmetic_part_if.sv
// Operand/opcode bundle into the arithmetic slice and its registered status out.
// The master drives operands and opcode; the slave (the slice) returns result and flags.
interface arithmetic_part_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUop;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             carry;
  logic             zero;
  logic             out_valid;

  modport master (
    output a, b, ALUop, in_valid,
    input  result, flag, carry, zero, out_valid
  );

  modport slave (
    input  a, b, ALUop, in_valid,
    output result, flag, carry, zero, out_valid
  );
endinterface

// File: rtl/arithmetic_part.sv
// ALU arithmetic slice: ADD / SUB / signed SLT on one shared adder; 1-cycle registered
// latency, no backpressure (registers load every cycle, in_valid only tags out_valid).
module arithmetic_part #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  arithmetic_part_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam int         MSB    = WIDTH - 1;

  logic             is_add;
  logic             is_sub;
  logic             is_slt;
  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] adder_res;
  logic             adder_cout;
  logic             adder_ovf;
  logic             slt_bit;

  logic [WIDTH-1:0] result_d;
  logic             flag_d;
  logic             carry_d;
  logic             zero_d;

  logic [WIDTH-1:0] result_q;
  logic             flag_q;
  logic             carry_q;
  logic             zero_q;
  logic             valid_q;

  // Unknown or foreign codes (including X) land in default and select nothing.
  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    is_slt = 1'b0;
    case (bus.ALUop)
      OP_ADD:  is_add = 1'b1;
      OP_SUB:  is_sub = 1'b1;
      OP_SLT:  is_slt = 1'b1;
      default: ;
    endcase
  end

  assign sub_mode   = is_sub | is_slt;
  assign b_eff      = sub_mode ? ~bus.b : bus.b;
  assign sum        = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
  assign adder_res  = sum[WIDTH-1:0];
  assign adder_cout = sum[WIDTH];

  // With b already inverted for SUB, one same-sign rule covers both ADD and SUB overflow.
  assign adder_ovf  = (bus.a[MSB] == b_eff[MSB]) && (adder_res[MSB] != bus.a[MSB]);

  // Sign of a-b is wrong exactly when the subtraction overflowed.
  assign slt_bit    = adder_res[MSB] ^ adder_ovf;

  always_comb begin
    result_d = '0;
    flag_d   = 1'b0;
    carry_d  = 1'b0;
    if (is_add || is_sub) begin
      result_d = adder_res;
      flag_d   = adder_ovf;
      carry_d  = adder_cout;
    end else if (is_slt) begin
      result_d = {{(WIDTH-1){1'b0}}, slt_bit};
    end
  end

  assign zero_d = (result_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flag_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      valid_q  <= bus.in_valid;
    end
  end

  assign bus.result    = result_q;
  assign bus.flag      = flag_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_arithmetic_part.sv
// Randomized + directed check of arithmetic_part against an integer-arithmetic reference.
module tb_arithmetic_part;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  arithmetic_part_if #(.WIDTH(W)) bus ();

  arithmetic_part #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference built from signed/unsigned integer arithmetic, not from adder bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                       output logic [W-1:0] r, output logic f, output logic c);
    longint sa, sb, sres;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r = '0;
    f = 1'b0;
    c = 1'b0;
    case (op)
      4'b0010: begin
        r    = a + b;
        c    = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        sres = sa + sb;
        f    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'b0110: begin
        r    = a - b;
        c    = (ua >= ub);
        sres = sa - sb;
        f    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ;
    endcase
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op, input logic v);
    bus.a        = a;
    bus.b        = b;
    bus.ALUop    = op;
    bus.in_valid = v;
  endtask

  // Apply one vector before a rising edge and compare at the following falling edge.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] op, input logic v);
    logic [W-1:0] er;
    logic ef, ec;
    drive(a, b, op, v);
    model(a, b, op, er, ef, ec);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".result"}, 64'(bus.result), 64'(er));
    check({tag, ".flag"},   64'(bus.flag),   64'(ef));
    check({tag, ".carry"},  64'(bus.carry),  64'(ec));
    check({tag, ".zero"},   64'(bus.zero),   64'(er == '0));
    check({tag, ".valid"},  64'(bus.out_valid), 64'(v));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".result"}, 64'(bus.result), 64'd0);
    check({tag, ".flag"},   64'(bus.flag),   64'd0);
    check({tag, ".carry"},  64'(bus.carry),  64'd0);
    check({tag, ".zero"},   64'(bus.zero),   64'd1);
    check({tag, ".valid"},  64'(bus.out_valid), 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;
    corners[4] = 32'h0000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 4'b0010;
      1: return 4'b0110;
      2: return 4'b0111;
      3: return 4'b0000;
      default: return 4'($urandom());
    endcase
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive($urandom(), $urandom(), 4'b0010, 1'b1);
    @(negedge clk);
    check_reset_state("rst_hold");

    rst = 1'b0;
    step("add_6_16",   32'd6, 32'd16, 4'b0010, 1'b1);
    step("add_30_6",   32'd30, 32'd6, 4'b0010, 1'b1);
    step("op0000",     32'd30, 32'd6, 4'b0000, 1'b1);
    step("add_wrap",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 1'b1);
    step("add_ovf",    32'h7FFF_FFFF, 32'd1, 4'b0010, 1'b1);
    step("sub_30_6",   32'd30, 32'd6, 4'b0110, 1'b1);
    step("sub_ovf",    32'h8000_0000, 32'd1, 4'b0110, 1'b1);
    step("sub_zero",   32'd5, 32'd5, 4'b0110, 1'b1);
    step("slt_neg",    32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b1);
    step("slt_ovf",    32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 1'b1);
    step("slt_ovf2",   32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, 1'b1);

    // Single-cycle valid pulse must reappear exactly one edge later, and only once.
    step("vpre",  32'd1, 32'd2, 4'b0010, 1'b0);
    step("vpul",  32'd3, 32'd4, 4'b0010, 1'b1);
    step("vpost", 32'd5, 32'd6, 4'b0010, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), pick_operand(), pick_operand(), pick_op(),
           1'($urandom_range(0, 1)));
    end

    // Mid-stream reset lands between edges and must clear outputs immediately.
    step("pre_rst", 32'd100, 32'd23, 4'b0010, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("rst_async");
    @(negedge clk);
    check_reset_state("rst_held");
    rst = 1'b0;
    step("post_rst", 32'd9, 32'd4, 4'b0110, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arithmetic_part.md
Name: arithmetic_part

Overview:
- Arithmetic slice of the ALU: add, subtract and signed set-less-than on two operands, selected by a 4-bit ALU control code.
- Produces a registered result plus a signed-overflow flag, a carry-out and a zero indication.
- Sits beside the logic slice; the ALU top muxes between slices by ALUop.
- Single-cycle registered datapath with a valid pipeline bit.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A (two's complement for signed ops).
- b  input  WIDTH  operand B.
- ALUop  input  4  operation select.
- in_valid  input  1  operands/op valid this cycle.
- result  output  WIDTH  registered result.
- flag  output  1  registered signed-overflow flag.
- carry  output  1  registered unsigned carry-out (ADD) / no-borrow (SUB).
- zero  output  1  registered, high when result == 0.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset (async, rst=1): result=0, flag=0, carry=0, zero=1, out_valid=0; held while rst high.
- Latency: 1 cycle. Outputs for inputs sampled at edge N appear after edge N.
  - Registers update every cycle regardless of in_valid.
  - in_valid only qualifies out_valid.
- ALUop 4'b0010 ADD:
  - result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum.
  - flag = 1 iff a,b have the same sign and the result sign differs.
- ALUop 4'b0110 SUB:
  - result = (a-b) mod 2^WIDTH, computed as a + ~b + 1; carry = carry-out of that add (1 = no borrow).
  - flag = 1 iff a,b have different signs and the result sign differs from a.
- ALUop 4'b0111 SLT:
  - result = {WIDTH-1 zeros, (signed a < signed b)}; comparison is correct even when a-b overflows.
  - flag=0, carry=0.
- Any other ALUop (including 4'b0000, owned by the logic slice): result=0, flag=0, carry=0.
- zero is computed from the result value being registered.
- A single shared adder serves ADD/SUB/SLT (b inverted, carry-in 1 for SUB/SLT).
- Reset asserted mid-stream clears outputs immediately; the first valid output after release appears one edge after in_valid is sampled.
- No X propagation: unknown ALUop codes resolve to the default case.

Test Plan:
- Reset: assert rst with random inputs -> result=0, flag=0, carry=0, zero=1, out_valid=0, asynchronously without a clock edge.
- ADD: a=6, b=16, ALUop=0010 -> next edge result=0x16, flag=0, carry=0. Then a=30, b=6 -> result=0x24, flag=0.
- Unsupported op and wrap: a=30, b=6, ALUop=0000 -> result=0, flag=0, zero=1. Then a=b=0xFFFFFFFF, ALUop=0010 -> result=0xFFFFFFFE, carry=1, flag=0.
- ADD overflow: a=0x7FFFFFFF, b=1, ADD -> result=0x80000000, flag=1, carry=0.
- SUB: a=30, b=6 -> result=24, carry=1, flag=0. a=0x80000000, b=1 -> result=0x7FFFFFFF, flag=1. a=5, b=5 -> zero=1.
- SLT and valid pipeline:
  - a=0xFFFFFFFF, b=1, SLT -> result=1.
  - a=0x7FFFFFFF, b=0x80000000 -> result=0.
  - in_valid pulsed one cycle -> out_valid pulses exactly one cycle later.
